// File: rtl/mask_encoder32_pkg.sv
// rtl/mask_encoder32_pkg.sv - shared state encoding and default widths for mask_encoder32
package mask_encoder32_pkg;

    localparam int N_DEF = 32;
    localparam int W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mask_encoder32_prio_enc32.sv
// rtl/mask_encoder32_prio_enc32.sv - combinational N-to-W priority encoder with any-set flag
module prio_enc32
    import mask_encoder32_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int W          = W_DEF,
    parameter int HIGH_FIRST = 0
) (
    input  logic [N-1:0] i_mask,
    output logic [W-1:0] o_sel,
    output logic         o_any
);

    // Scan so that the winning bit is the last one assigned.
    always_comb begin
        o_sel = '0;
        o_any = |i_mask;
        if (HIGH_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (i_mask[i]) o_sel = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_mask[i]) o_sel = W'(i);
            end
        end
    end

endmodule

// File: rtl/mask_encoder32.sv
// rtl/mask_encoder32.sv - emits the index of every set bit of a captured mask, one per handshake
module mask_encoder32
    import mask_encoder32_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int W          = W_DEF,
    parameter int HIGH_FIRST = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [N-1:0] i_req,
    input  logic         i_abort,
    input  logic         i_ready,
    output logic [W-1:0] o_idx,
    output logic         o_valid,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_empty,
    output logic [W:0]   o_count
);

    state_t       r_state;
    logic [N-1:0] r_pending;
    logic [W-1:0] r_idx;
    logic         r_valid;
    logic         r_done;
    logic         r_empty;
    logic [W:0]   r_count;

    state_t       w_state_nxt;
    logic [N-1:0] w_pending_nxt;
    logic [W-1:0] w_idx_nxt;
    logic         w_valid_nxt;
    logic         w_done_nxt;
    logic         w_empty_nxt;
    logic [W:0]   w_count_nxt;

    logic [N-1:0] w_enc_in;
    logic [W-1:0] w_sel;
    logic         w_any;
    logic [N-1:0] w_sel_bit;

    // One encoder serves both the capture (req) and the drain (pending).
    assign w_enc_in  = (r_state == ST_IDLE) ? i_req : r_pending;
    assign w_sel_bit = N'(1) << w_sel;

    prio_enc32 #(
        .N          (N),
        .W          (W),
        .HIGH_FIRST (HIGH_FIRST)
    ) u_prio_enc (
        .i_mask (w_enc_in),
        .o_sel  (w_sel),
        .o_any  (w_any)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_done_nxt    = 1'b0;
        w_empty_nxt   = 1'b0;
        w_count_nxt   = r_count;
        case (r_state)
            ST_IDLE: begin
                if (i_load) begin
                    w_count_nxt = '0;
                    if (w_any) begin
                        w_idx_nxt     = w_sel;
                        w_valid_nxt   = 1'b1;
                        w_pending_nxt = i_req & ~w_sel_bit;
                        w_state_nxt   = ST_EMIT;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_empty_nxt = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_EMIT: begin
                if (i_abort) begin
                    w_pending_nxt = '0;
                    w_valid_nxt   = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else if (r_valid && i_ready) begin
                    w_count_nxt = r_count + (W+1)'(1);
                    if (w_any) begin
                        w_idx_nxt     = w_sel;
                        w_pending_nxt = r_pending & ~w_sel_bit;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_pending_nxt = '0;
                w_valid_nxt   = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
            default: begin
                w_pending_nxt = '0;
                w_valid_nxt   = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_empty   <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
            r_empty   <= w_empty_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign o_idx   = r_idx;
    assign o_valid = r_valid;
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = r_done;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: tb/tb_mask_encoder32.sv
// tb/tb_mask_encoder32.sv - self-checking bench for mask_encoder32 in both emission orders
module tb_mask_encoder32;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] req;
    logic        abort;
    logic        ready;

    logic [4:0]  idx_lo,   idx_hi;
    logic        valid_lo, valid_hi;
    logic        busy_lo,  busy_hi;
    logic        done_lo,  done_hi;
    logic        empty_lo, empty_hi;
    logic [5:0]  count_lo, count_hi;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mask_encoder32 #(.N(32), .W(5), .HIGH_FIRST(0)) u_lo (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_req(req), .i_abort(abort), .i_ready(ready),
        .o_idx(idx_lo), .o_valid(valid_lo), .o_busy(busy_lo), .o_done(done_lo),
        .o_empty(empty_lo), .o_count(count_lo)
    );

    mask_encoder32 #(.N(32), .W(5), .HIGH_FIRST(1)) u_hi (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_req(req), .i_abort(abort), .i_ready(ready),
        .o_idx(idx_hi), .o_valid(valid_hi), .o_busy(busy_hi), .o_done(done_hi),
        .o_empty(empty_hi), .o_count(count_hi)
    );

    typedef struct {
        logic [31:0] req;
        int          first_lo;
        int          first_hi;
        int          count;
        logic        empty;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: the expected index stream is just the set bits listed in order.
    task automatic run_mask(input logic [31:0] m, input int rdy_pct,
                            output int f_lo, output int f_hi, output int cnt);
        int q_lo[$];
        int q_hi[$];
        int total;
        int cyc;
        bit r;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                q_lo.push_back(i);
                q_hi.push_front(i);
            end
        end
        total = q_lo.size();
        @(negedge clk);
        load = 1'b1; req = m; abort = 1'b0; ready = 1'b0;
        @(negedge clk);
        load = 1'b0; req = $urandom;
        f_lo = int'(idx_lo);
        f_hi = int'(idx_hi);
        cyc  = 0;
        while (q_lo.size() > 0 && cyc < 400) begin
            chk("valid_lo", 64'(valid_lo), 64'd1);
            chk("valid_hi", 64'(valid_hi), 64'd1);
            chk("busy", 64'(busy_lo), 64'd1);
            chk("done_early", 64'(done_lo), 64'd0);
            chk("idx_lo", 64'(idx_lo), 64'(q_lo[0]));
            chk("idx_hi", 64'(idx_hi), 64'(q_hi[0]));
            chk("count_run", 64'(count_lo), 64'(total - q_lo.size()));
            r     = ($urandom_range(99) < rdy_pct);
            ready = r;
            load  = ($urandom_range(3) == 0);
            req   = $urandom;
            if (r) begin
                void'(q_lo.pop_front());
                void'(q_hi.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        ready = 1'b0; load = 1'b0;
        if (q_lo.size() != 0) chk("emit_timeout", 64'(q_lo.size()), 64'd0);
        chk("done_lo", 64'(done_lo), 64'd1);
        chk("done_hi", 64'(done_hi), 64'd1);
        chk("empty", 64'(empty_lo), 64'(m == 32'd0));
        chk("valid_at_done", 64'(valid_lo), 64'd0);
        chk("count_lo", 64'(count_lo), 64'(total));
        chk("count_hi", 64'(count_hi), 64'(total));
        cnt = int'(count_lo);
        @(negedge clk);
        chk("done_pulse", 64'(done_lo), 64'd0);
        chk("empty_clear", 64'(empty_lo), 64'd0);
        chk("busy_idle", 64'(busy_hi), 64'd0);
        chk("count_hold", 64'(count_lo), 64'(total));
    endtask

    initial begin
        vec_t vecs[6];
        int   f_lo, f_hi, cnt;
        logic [31:0] m;

        vecs[0] = '{32'h0000_0001, 0,  0,  1,  1'b0};
        vecs[1] = '{32'h8000_0011, 0,  31, 3,  1'b0};
        vecs[2] = '{32'h0000_0000, 0,  0,  0,  1'b1};
        vecs[3] = '{32'h0000_000C, 2,  3,  2,  1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 0,  31, 32, 1'b0};
        vecs[5] = '{32'h8000_0000, 31, 31, 1,  1'b0};

        rst = 1'b1; load = 1'b0; req = '0; abort = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(valid_lo), 64'd0);
        chk("rst_busy", 64'(busy_lo), 64'd0);
        chk("rst_idx", 64'(idx_lo), 64'd0);
        chk("rst_count", 64'(count_hi), 64'd0);
        chk("rst_done", 64'(done_hi), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_mask(vecs[v].req, 100, f_lo, f_hi, cnt);
            if (!vecs[v].empty) begin
                chk("vec_first_lo", 64'(f_lo), 64'(vecs[v].first_lo));
                chk("vec_first_hi", 64'(f_hi), 64'(vecs[v].first_hi));
            end
            chk("vec_count", 64'(cnt), 64'(vecs[v].count));
        end

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(3))
                0: m = $urandom;
                1: m = $urandom & $urandom & $urandom;
                2: m = 32'd1 << $urandom_range(31);
                default: m = (t % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF;
            endcase
            run_mask(m, int'($urandom_range(100, 30)), f_lo, f_hi, cnt);
        end

        // Stall: idx must hold while ready is low.
        @(negedge clk);
        load = 1'b1; req = 32'h0000_000C; ready = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_idx", 64'(idx_lo), 64'd2);
            chk("stall_valid", 64'(valid_lo), 64'd1);
            @(negedge clk);
        end
        ready = 1'b1;
        chk("stall_accept_idx", 64'(idx_lo), 64'd2);
        @(negedge clk);
        chk("stall_next_idx", 64'(idx_lo), 64'd3);
        @(negedge clk);
        ready = 1'b0;
        chk("stall_done", 64'(done_lo), 64'd1);
        chk("stall_count", 64'(count_lo), 64'd2);
        @(negedge clk);

        // Abort after six accepts, with load ignored mid-stream.
        load = 1'b1; req = 32'hFFFF_FFFF; ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("abort_seq_idx", 64'(idx_lo), 64'(k));
            load = (k == 2);
            req  = 32'h1;
            @(negedge clk);
        end
        load = 1'b1; abort = 1'b1;
        @(negedge clk);
        load = 1'b0; abort = 1'b0; ready = 1'b0;
        chk("abort_valid", 64'(valid_lo), 64'd0);
        chk("abort_busy", 64'(busy_lo), 64'd0);
        chk("abort_done", 64'(done_lo), 64'd0);
        chk("abort_count", 64'(count_lo), 64'd6);
        @(negedge clk);
        chk("abort_still_idle", 64'(valid_hi | done_hi), 64'd0);

        // load and abort together in IDLE: load wins.
        load = 1'b1; abort = 1'b1; req = 32'h0000_0010;
        @(negedge clk);
        load = 1'b0; abort = 1'b0; ready = 1'b1;
        chk("idle_load_abort_valid", 64'(valid_lo), 64'd1);
        chk("idle_load_abort_idx", 64'(idx_lo), 64'd4);
        @(negedge clk);
        ready = 1'b0;
        chk("idle_load_abort_done", 64'(done_lo), 64'd1);
        @(negedge clk);

        // Asynchronous reset in the middle of a stream.
        load = 1'b1; req = 32'hFFFF_FFFF; ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_lo), 64'd0);
        chk("arst_busy", 64'(busy_lo), 64'd0);
        chk("arst_idx", 64'(idx_lo), 64'd0);
        chk("arst_count", 64'(count_lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(valid_lo | valid_hi), 64'd0);
            chk("post_rst_busy", 64'(busy_lo | busy_hi), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
